// File: rtl/dma_utils_pkg.sv
// Shared DMA types and constants: burst-generator FSM states, the AXI 4 KB
// page size and the address-phase payload consumed by dma_streamer.
package dma_utils_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      ISSUE
   } dma_bg_st_t;

   localparam int unsigned AXI_4KB    = 4096;
   localparam int unsigned DMA_ADDR_W = 32;

   typedef struct packed {
      logic [DMA_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic                  last;
   } s_dma_burst_t;

   // Unsigned minimum of two 13-bit beat counts.
   function automatic logic [12:0] min13(input logic [12:0] a, input logic [12:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: the largest burst starting at the given page
// offset that respects the max burst length, the 4 KB page end and the
// bytes still to transfer. Shared with the descriptor checker.
module dma_burst_calc
   import dma_utils_pkg::*;
#(
   parameter int BYTES_WIDTH = 32,
   parameter int DATA_WIDTH  = 32
) (
   input  logic [11:0]            addr,       // offset within the 4 KB page
   input  logic [BYTES_WIDTH-1:0] remaining,
   input  logic [7:0]             maxb,
   output logic [12:0]            beats,
   output logic                   last
);

   localparam int BPB_LOG2 = $clog2(DATA_WIDTH / 8);

   logic [12:0]            beats_4k;
   logic [12:0]            beats_max;
   logic [12:0]            beats_rem;
   logic [BYTES_WIDTH-1:0] rem_beats_full;
   logic [BYTES_WIDTH-1:0] burst_bytes;

   // Take the smallest of the three limits; saturate the remaining-beat
   // count at one page so it fits the 13-bit compare.
   always_comb begin
      beats_4k       = (13'(AXI_4KB) - {1'b0, addr}) >> BPB_LOG2;
      beats_max      = {5'b0, maxb} + 13'd1;
      rem_beats_full = remaining >> BPB_LOG2;
      beats_rem      = (rem_beats_full > BYTES_WIDTH'(AXI_4KB)) ? 13'(AXI_4KB)
                                                                 : 13'(rem_beats_full);
      beats          = min13(min13(beats_max, beats_4k), beats_rem);
      burst_bytes    = BYTES_WIDTH'(beats) << BPB_LOG2;
      last           = (burst_bytes == remaining);
   end

endmodule

// File: rtl/dma_burst_gen.sv
// Address-phase burst generator: splits one transfer request into legal
// AXI bursts (max length, no 4 KB crossing, no overrun), one per handshake.
module dma_burst_gen
   import dma_utils_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BYTES_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [BYTES_WIDTH-1:0] req_bytes_i,
   input  logic [7:0]             req_maxb_i,
   output logic                   burst_valid_o,
   input  logic                   burst_ready_i,
   output logic [ADDR_WIDTH-1:0]  burst_addr_o,
   output logic [7:0]             burst_len_o,
   output logic                   burst_last_o,
   output logic                   done_o,
   output logic                   err_o
);

   localparam int BPB      = DATA_WIDTH / 8;
   localparam int BPB_LOG2 = $clog2(BPB);
   localparam int SUM_W    = ((ADDR_WIDTH > BYTES_WIDTH) ? ADDR_WIDTH : BYTES_WIDTH) + 1;

   dma_bg_st_t state, state_nxt;

   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [BYTES_WIDTH-1:0] rem_q;
   logic [7:0]             maxb_q;
   logic [ADDR_WIDTH-1:0]  burst_addr_q;
   logic [7:0]             burst_len_q;
   logic                   burst_last_q;
   logic                   done_q;
   logic                   err_q;

   logic                   accept;
   logic                   load_burst;
   logic                   advance;
   logic                   done_nxt;
   logic                   err_nxt;
   logic                   misaligned;
   logic                   overflow;
   logic [SUM_W-1:0]       req_end;
   logic [SUM_W-1:0]       addr_limit;
   logic [12:0]            calc_beats;
   logic                   calc_last;
   logic [8:0]             issued_beats;
   logic [ADDR_WIDTH-1:0]  step_addr;
   logic [BYTES_WIDTH-1:0] step_bytes;

   dma_burst_calc #(
      .BYTES_WIDTH (BYTES_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH)
   ) u_calc (
      .addr      (addr_q[11:0]),
      .remaining (rem_q),
      .maxb      (maxb_q),
      .beats     (calc_beats),
      .last      (calc_last)
   );

   // Request legality: beat alignment and end address within the space,
   // summed one bit wider so a wrap past the top is visible.
   always_comb begin
      req_end    = SUM_W'(req_addr_i) + SUM_W'(req_bytes_i);
      addr_limit = SUM_W'(1) << ADDR_WIDTH;
      misaligned = ((req_addr_i & ADDR_WIDTH'(BPB - 1)) != '0) ||
                   ((req_bytes_i & BYTES_WIDTH'(BPB - 1)) != '0);
      overflow   = (req_end > addr_limit);
   end

   // Byte advance of the burst just accepted, derived from its AxLEN.
   always_comb begin
      issued_beats = {1'b0, burst_len_q} + 9'd1;
      step_addr    = ADDR_WIDTH'(issued_beats) << BPB_LOG2;
      step_bytes   = BYTES_WIDTH'(issued_beats) << BPB_LOG2;
   end

   // Next-state and control strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt  = state;
      accept     = 1'b0;
      load_burst = 1'b0;
      advance    = 1'b0;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid_i) begin
               accept = 1'b1;
               if (misaligned || overflow) begin
                  err_nxt = 1'b1;
               end else if (req_bytes_i == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt = CALC;
               end
            end
         end
         CALC: begin
            load_burst = 1'b1;
            state_nxt  = ISSUE;
         end
         ISSUE: begin
            if (burst_ready_i) begin
               advance = 1'b1;
               if (burst_last_q) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = CALC;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its inputs.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request bookkeeping, burst descriptor and status pulses.
   always_ff @(posedge clk) begin
      // NOTE: the datapath is reset along with the FSM because the burst
      // outputs and pulses have defined reset values and an aborted request
      // must not leak a stale descriptor.
      if (rst) begin
         addr_q       <= '0;
         rem_q        <= '0;
         maxb_q       <= '0;
         burst_addr_q <= '0;
         burst_len_q  <= '0;
         burst_last_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         done_q <= done_nxt;
         err_q  <= err_nxt;
         if (accept) begin
            addr_q <= req_addr_i;
            rem_q  <= req_bytes_i;
            maxb_q <= req_maxb_i;
         end
         if (load_burst) begin
            burst_addr_q <= addr_q;
            burst_len_q  <= 8'(calc_beats - 13'd1);
            burst_last_q <= calc_last;
         end
         if (advance) begin
            addr_q <= addr_q + step_addr;
            rem_q  <= rem_q - step_bytes;
         end
      end
   end

   assign req_ready_o   = (state == IDLE);
   assign burst_valid_o = (state == ISSUE);
   assign burst_addr_o  = burst_addr_q;
   assign burst_len_o   = burst_len_q;
   assign burst_last_o  = burst_last_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule

// File: doc/dma_burst_gen.md
# dma_burst_gen

Address-phase burst generator between `dma_streamer` and the AXI master interface. It accepts one transfer request (start address, byte count, max burst length) and emits a legal sequence of AXI bursts (address, AxLEN), one per handshake. Each burst is capped by the max burst length, never crosses a 4 KB boundary, and never overruns the byte count. One instance serves the read channel and one serves the write channel.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: AXI data width. BPB = DATA_WIDTH/8 bytes per beat, a power of two.
- `BYTES_WIDTH`, default 32: width of the byte-count field.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  transfer request valid.
- `req_ready_o`  out  1  request accepted; high only in IDLE.
- `req_addr_i`  in  ADDR_WIDTH  start address.
- `req_bytes_i`  in  BYTES_WIDTH  total bytes to transfer.
- `req_maxb_i`  in  8  maximum AxLEN; beats per burst ≤ req_maxb_i+1.
- `burst_valid_o`  out  1  burst descriptor valid.
- `burst_ready_i`  in  1  AXI address channel accepts the burst.
- `burst_addr_o`  out  ADDR_WIDTH  burst start address.
- `burst_len_o`  out  8  AxLEN (beats-1).
- `burst_last_o`  out  1  this is the final burst of the request.
- `done_o`  out  1  one-cycle pulse: request fully issued.
- `err_o`  out  1  one-cycle pulse: request rejected; no bursts issued.

## Operation
- FSM states: IDLE, CALC, ISSUE.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`, latch addr, bytes and maxb.
  - Check order: `err_o` pulse, stay IDLE, if addr or bytes is not BPB-aligned, or if addr+bytes > 2^ADDR_WIDTH (compute with one extra bit).
  - Else if bytes==0: `done_o` pulse, stay IDLE.
  - Else go to CALC.
- **CALC**
  - beats_4k = (4096 - addr[11:0]) / BPB.
  - beats_rem = remaining / BPB.
  - beats = min(maxb+1, beats_4k, beats_rem).
  - Register burst_addr=addr, burst_len=beats-1, and burst_last=(beats*BPB==remaining).
  - Go to ISSUE.
- **ISSUE**
  - `burst_valid_o`=1.
  - On `burst_ready_i`: addr += beats*BPB, remaining -= beats*BPB.
  - If last: `done_o` pulse in the cycle after the handshake, go to IDLE. Else go to CALC.
- Width rules:
  - beats and beats_4k are 13-bit intermediates.
  - remaining is BYTES_WIDTH wide.
  - The min result is ≤256, so burst_len always fits 8 bits.
- New requests are ignored (`req_ready_o`=0) outside IDLE.
- `req_maxb_i` changes after accept have no effect.

## Timing
- Reset values: `req_ready_o`=1, `burst_valid_o`=0, `burst_addr_o`=0, `burst_len_o`=0, `burst_last_o`=0, `done_o`=0, `err_o`=0. State is IDLE.
- Accept to first `burst_valid_o`: 2 cycles (accept edge → CALC → ISSUE).
- Handshake to next `burst_valid_o`: 2 cycles (one CALC bubble). Required throughput is one burst per 2 cycles.
- While `burst_valid_o`=1 and `burst_ready_i`=0, addr/len/last hold stable and valid never drops (AXI rule).
- `done_o`/`err_o` are registered and assert the cycle after the triggering edge. `req_ready_o` returns to 1 in that same cycle.
- Back-to-back requests: the next request may be accepted in the cycle `done_o` is high.
- `rst` mid-request: next cycle all outputs are at reset values. The in-flight request is dropped, with no done and no err.

## Structure
- Shared in `dma_utils_pkg`:
  - `dma_bg_st_t` enum (IDLE/CALC/ISSUE).
  - `AXI_4KB` = 4096 constant.
  - `s_dma_burst_t` struct {addr, len, last}. `dma_streamer` consumes it as the AXI address-phase payload.
- Optional combinational sub-module `dma_burst_calc` (addr, remaining, maxb → beats, last). It is reused by the descriptor checker.
- The rest is a single-file FSM.

## Test plan
DATA_WIDTH=32 (BPB=4) for all scenarios.
- addr 0x1000, bytes 64, maxb 255 → one burst: 0x1000/len 15/last=1, then `done_o` pulse.
- addr 0x0FF0, bytes 64, maxb 255 → two bursts: 0x0FF0/len 3/last=0, then 0x1000/len 11/last=1. No burst crosses 0x1000.
- addr 0x0, bytes 2048, maxb 15 → 32 bursts at 0x0, 0x40, …, 0x7C0, each len 15. Only the 32nd has last=1.
- Illegal requests:
  - bytes 0 → `done_o` 1 cycle after accept, no `burst_valid_o`.
  - addr 0x1002 → `err_o` pulse, no burst.
  - addr 0xFFFFFFF0, bytes 32 → `err_o` pulse, no burst.
- Backpressure: `burst_ready_i` held low 10 cycles in the scenario-2 sequence → valid, addr and len stable throughout; sequence completes unchanged.
- `rst` asserted while `burst_valid_o`=1 mid-sequence → next cycle valid=0, `req_ready_o`=1, no `done_o`. A new request then completes normally.
